alu_exec_unit: RTL and testbench

Execute-stage ALU that sits directly downstream of the ALU control decoder. It consumes the decoder's 4-bit `ALU_*` select plus two 32-bit operands and produces a registered result and flags for the memory/writeback path.
- Handshakes on both input and output.
- Non-shift ops complete in one cycle.
- Shifts are iterative, 1 bit per cycle, to save area; a single-cycle barrel shifter is available as the optional feature.

---
 rtl/alu_exec_unit_pkg.sv | 76 +++++++
 rtl/alu_exec_unit_shift_seq.sv | 58 +++++
 rtl/alu_exec_unit.sv | 114 +++++++++++
 tb/tb_alu_exec_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared types, ALU select codes and the combinational ALU function for alu_exec_unit.
package alu_exec_unit_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  typedef enum logic {
    EXU_IDLE  = 1'b0,
    EXU_SHIFT = 1'b1
  } exu_state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zf;
    logic            cf;
    logic            vf;
    logic            sf;
  } alu_out_t;

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

  // Shifts here are full barrel shifts; the iterative path only uses this for shamt==0.
  function automatic alu_out_t alu_compute(input logic [3:0] sel,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    alu_out_t            o;
    logic [XLEN:0]       sum;
    logic [XLEN:0]       diff;
    logic [SHAMT_W-1:0]  sh;
    o    = '0;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    sh   = b[SHAMT_W-1:0];
    case (sel)
      ALU_ADD, ALU_AUIPC: begin
        o.result = sum[XLEN-1:0];
        o.cf     = sum[XLEN];
        o.vf     = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        o.result = diff[XLEN-1:0];
        o.cf     = ~diff[XLEN];
        o.vf     = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:  o.result = a & b;
      ALU_OR:   o.result = a | b;
      ALU_XOR:  o.result = a ^ b;
      ALU_SLT:  o.result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: o.result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_LUI:  o.result = b;
      ALU_SLL:  o.result = a << sh;
      ALU_SRL:  o.result = a >> sh;
      ALU_SRA:  o.result = $unsigned($signed(a) >>> sh);
      default:  o.result = '0;
    endcase
    o.zf = (o.result == '0);
    o.sf = o.result[XLEN-1];
    return o;
  endfunction

endpackage

// File: rtl/alu_exec_unit_shift_seq.sv
// Bit-serial shifter: one position per cycle, done pulses in the cycle of the final shift.
module alu_shift_seq
  import alu_exec_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_kill,
  input  logic               i_start,
  input  logic [3:0]         i_sel,
  input  logic [XLEN-1:0]    i_a,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [XLEN-1:0]    o_acc_next,
  output logic               o_busy,
  output logic               o_done
);

  logic [XLEN-1:0]    r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [3:0]         r_sel;
  logic               r_busy;
  logic [XLEN-1:0]    w_acc_next;

  always_comb begin
    w_acc_next = r_acc;
    case (r_sel)
      ALU_SLL: w_acc_next = {r_acc[XLEN-2:0], 1'b0};
      ALU_SRL: w_acc_next = {1'b0, r_acc[XLEN-1:1]};
      ALU_SRA: w_acc_next = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
      default: w_acc_next = r_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sel  <= '0;
      r_busy <= 1'b0;
    end else if (i_kill) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_acc  <= i_a;
      r_cnt  <= i_shamt;
      r_sel  <= i_sel;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == SHAMT_W'(1)) r_busy <= 1'b0;
    end
  end

  assign o_acc_next = w_acc_next;
  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == SHAMT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides and a registered result/flag slot.
// FAST_SHIFT_EN: single-cycle barrel shifts instead of the bit-serial shifter.
//
// state     | meaning
// EXU_IDLE  | ready for a new op (subject to output slot and flush)
// EXU_SHIFT | bit-serial shift in progress, busy=1
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      sel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            cf,
  output logic            vf,
  output logic            sf,
  output logic            busy
);

  exu_state_t      r_state;
  exu_state_t      w_state_next;
  logic            r_out_valid;
  alu_out_t        r_out;
  alu_out_t        w_alu;
  logic            w_iter;
  logic            w_accept;
  logic            w_start_shift;
  logic            w_capture;
  logic [XLEN-1:0] w_acc_next;
  logic            w_sh_busy;
  logic            w_sh_done;

  assign w_alu = alu_compute(sel, a, b);

`ifdef FAST_SHIFT_EN
  assign w_iter     = 1'b0;
  assign w_acc_next = '0;
  assign w_sh_busy  = 1'b0;
  assign w_sh_done  = 1'b0;
`else
  assign w_iter = is_shift(sel) && (b[SHAMT_W-1:0] != '0);

  alu_shift_seq u_shift_seq (
    .clk        (clk),
    .rst        (rst),
    .i_kill     (flush),
    .i_start    (w_start_shift),
    .i_sel      (sel),
    .i_a        (a),
    .i_shamt    (b[SHAMT_W-1:0]),
    .o_acc_next (w_acc_next),
    .o_busy     (w_sh_busy),
    .o_done     (w_sh_done)
  );
`endif

  assign in_ready      = (r_state == EXU_IDLE) && !flush && (!r_out_valid || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_start_shift = w_accept && w_iter;
  assign w_capture     = w_accept && !w_iter;

  always_ff @(posedge clk) begin
    if (rst) r_state <= EXU_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EXU_IDLE:  if (w_start_shift)        w_state_next = EXU_SHIFT;
      EXU_SHIFT: if (flush || w_sh_done)   w_state_next = EXU_IDLE;
      default:                             w_state_next = EXU_IDLE;
    endcase
  end

  // Flush only invalidates the slot; the stale result/flags are left in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out       <= w_alu;
      r_out_valid <= 1'b1;
    end else if (w_sh_done) begin
      r_out.result <= w_acc_next;
      r_out.zf     <= (w_acc_next == '0);
      r_out.cf     <= 1'b0;
      r_out.vf     <= 1'b0;
      r_out.sf     <= w_acc_next[XLEN-1];
      r_out_valid  <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_out.result;
  assign zf        = r_out.zf;
  assign cf        = r_out.cf;
  assign vf        = r_out.vf;
  assign sf        = r_out.sf;
  assign busy      = w_sh_busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, scoreboard queue and shift/flush/reset sequences.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic        in_ready, out_valid, zf, cf, vf, sf, busy;
  logic [3:0]  sel;
  logic [31:0] a, b, result;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zf(zf), .cf(cf), .vf(vf), .sf(sf), .busy(busy)
  );

`ifdef FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] result;
    logic        zf, cf, vf, sf;
  } exp_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  vec_t vecs[15];
  exp_t sb[$];
  exp_t pend;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_out    = 0;
  bit   acc_flag, last_out, s_in_ready, s_busy, s_out_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [31:0] aa, input logic [31:0] bb,
                       input exp_t e);
    sel = s; a = aa; b = bb; pend = e; in_valid = 1'b1;
  endtask

  // One cycle: settle, record handshakes against the scoreboard, advance to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    s_in_ready  = in_ready;
    s_busy      = busy;
    s_out_valid = out_valid;
    acc_flag    = in_valid && in_ready;
    if (acc_flag) sb.push_back(pend);
    last_out = out_valid && out_ready && !flush && !rst;
    if (last_out) begin
      n_out++;
      if (sb.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_output: got %h want none", result);
      end else begin
        e = sb.pop_front();
        chk($sformatf("out%0d", n_out), {result, zf, cf, vf, sf}, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic run_single(input string nm, input logic [3:0] s, input logic [31:0] aa,
                            input logic [31:0] bb, input exp_t e, input int exp_lat,
                            input int exp_busy);
    int lat;
    int bcnt;
    bit got;
    out_ready = 1'b1;
    drive(s, aa, bb, e);
    tick();
    chk($sformatf("%s_accept", nm), acc_flag, 1);
    in_valid = 1'b0;
    lat = 0; bcnt = 0; got = 1'b0;
    while (!got && lat < 80) begin
      lat++;
      tick();
      bcnt += int'(s_busy);
      got = last_out;
    end
    chk($sformatf("%s_latency", nm), lat, exp_lat);
    chk($sformatf("%s_busy_cycles", nm), bcnt, exp_busy);
  endtask

  initial begin
    int base;
    vecs[0]  = '{ALU_ADD,   32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 0, 0, 1, 1}};
    vecs[1]  = '{ALU_SUB,   32'h00000005, 32'h00000005, '{32'h00000000, 1, 1, 0, 0}};
    vecs[2]  = '{ALU_SLTU,  32'h00000001, 32'hFFFFFFFF, '{32'h00000001, 0, 0, 0, 0}};
    vecs[3]  = '{ALU_SLT,   32'h00000001, 32'hFFFFFFFF, '{32'h00000000, 1, 0, 0, 0}};
    vecs[4]  = '{ALU_ADD,   32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1, 1, 0, 0}};
    vecs[5]  = '{ALU_SUB,   32'h00000003, 32'h00000005, '{32'hFFFFFFFE, 0, 0, 0, 1}};
    vecs[6]  = '{ALU_SUB,   32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 0, 1, 1, 0}};
    vecs[7]  = '{ALU_AND,   32'hF0F0F0F0, 32'hFF00FF00, '{32'hF000F000, 0, 0, 0, 1}};
    vecs[8]  = '{ALU_OR,    32'h0000F0F0, 32'h00000F0F, '{32'h0000FFFF, 0, 0, 0, 0}};
    vecs[9]  = '{ALU_XOR,   32'h000000F0, 32'h000000FF, '{32'h0000000F, 0, 0, 0, 0}};
    vecs[10] = '{ALU_LUI,   32'h00000123, 32'hABCDE000, '{32'hABCDE000, 0, 0, 0, 1}};
    vecs[11] = '{ALU_AUIPC, 32'h00001000, 32'hFFFFF000, '{32'h00000000, 1, 1, 0, 0}};
    vecs[12] = '{4'hF,      32'h00000001, 32'h00000002, '{32'h00000000, 1, 0, 0, 0}};
    vecs[13] = '{ALU_SLL,   32'h12345678, 32'h00000020, '{32'h12345678, 0, 0, 0, 0}};
    vecs[14] = '{ALU_SLT,   32'hFFFFFFFB, 32'h00000003, '{32'h00000001, 0, 0, 0, 0}};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    sel = '0; a = '0; b = '0; pend = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {out_valid, busy, result, zf, cf, vf, sf}, '0);
    chk("reset_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Streaming vector table, one op per cycle.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].e);
      tick();
      chk($sformatf("vec%0d_accept", i), acc_flag, 1);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("table_drained", sb.size(), 0);

    // Ten back-to-back ADDs -> ten results on ten consecutive cycles.
    base = n_out;
    for (int i = 0; i < 10; i++) begin
      drive(ALU_ADD, 32'(i * 3), 32'd100, '{32'(i * 3 + 100), 0, 0, 0, 0});
      tick();
      chk($sformatf("b2b%0d_accept", i), acc_flag, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_outputs", n_out - base, 10);

    // Shifts.
    run_single("sra4",  ALU_SRA, 32'h80000000, 32'd4,  '{32'hF8000000, 0, 0, 0, 1},
               FAST ? 1 : 5,  FAST ? 0 : 4);
    run_single("srl31", ALU_SRL, 32'h80000000, 32'd31, '{32'h00000001, 0, 0, 0, 0},
               FAST ? 1 : 32, FAST ? 0 : 31);
    run_single("sll1",  ALU_SLL, 32'h00000003, 32'd1,  '{32'h00000006, 0, 0, 0, 0},
               FAST ? 1 : 2,  FAST ? 0 : 1);

    // Backpressure: 7 held while out_ready low, then drain + capture in one cycle.
    out_ready = 1'b0;
    drive(ALU_ADD, 32'd3, 32'd4, '{32'd7, 0, 0, 0, 0});
    tick();
    chk("bp_accept", acc_flag, 1);
    drive(ALU_ADD, 32'd1, 32'd1, '{32'd2, 0, 0, 0, 0});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), {s_out_valid, s_in_ready, result}, {1'b1, 1'b0, 32'd7});
    end
    out_ready = 1'b1;
    tick();
    chk("bp_drain_and_accept", {last_out, acc_flag}, 2'b11);
    in_valid = 1'b0;
    tick();
    chk("bp_second_out", last_out, 1);

    // Flush on the second cycle of a long shift.
    drive(ALU_SLL, 32'd1, 32'd20, '{32'h00100000, 0, 0, 0, 0});
    tick();
    chk("flush_accept", acc_flag, 1);
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    tick();
    chk("flush_idle", {s_in_ready, s_busy, s_out_valid}, 3'b100);
    base = n_out;
    repeat (25) tick();
    chk("flush_no_output", n_out - base, 0);
    run_single("xor_after_flush", ALU_XOR, 32'hF0, 32'hFF, '{32'h0F, 0, 0, 0, 0}, 1, 0);

    // Reset in the middle of a shift.
    drive(ALU_SRL, 32'hFFFFFFFF, 32'd10, '{32'h003FFFFF, 0, 0, 0, 0});
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_shift", {out_valid, busy, result, in_ready}, {1'b0, 1'b0, 32'd0, 1'b1});
    @(negedge clk);
    base = n_out;
    repeat (15) tick();
    chk("rst_no_output", n_out - base, 0);
    run_single("add_after_rst", ALU_ADD, 32'd10, 32'd20, '{32'd30, 0, 0, 0, 0}, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
